// File: rtl/p2_rtl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p2_rtl_pkg
// Description : Shared constants and helpers for the p2_rtl function unit.
// Revision    : 1.0 - initial release
// ============================================================================
package p2_rtl_pkg;

    localparam logic [7:0] P2_TT_DEFAULT          = 8'hEA;
    localparam int         P2_SYNC_STAGES_DEFAULT = 2;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage : p2_rtl_pkg
`default_nettype wire

// File: rtl/p2_sync.sv
`default_nettype none
// ============================================================================
// Module      : p2_sync
// Description : Single-bit multi-flop synchronizer, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module p2_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : p2_sync
`default_nettype wire

// File: rtl/p2_rtl.sv
`default_nettype none
// ============================================================================
// Module      : p2_rtl
// Description : Registered 3-input truth-table function unit with edge and
//               non-Gray step flags, for asynchronous switch inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module p2_rtl
    import p2_rtl_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = P2_TT_DEFAULT,
    parameter int         SYNC_STAGES = P2_SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       f,
    output logic [2:0] abc_q,
    output logic       f_rise,
    output logic       f_fall,
    output logic       step_err,
    output logic       step_err_sticky
);

    logic [2:0] w_raw;
    logic [2:0] w_s;
    logic       w_f_next;
    logic       w_step_bad;

    logic [2:0] r_abc_q;
    logic       r_f;
    logic       r_f_rise;
    logic       r_f_fall;
    logic       r_step_err;
    logic       r_step_err_sticky;

    assign w_raw = {a, b, c};

    // Each bit is synchronized independently, so a multi-bit input change
    // may land across different clocks; the step check exposes that.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            p2_sync #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (w_raw[gi]),
                .o_q   (w_s[gi])
            );
        end
    endgenerate

    assign w_f_next   = TRUTH_TABLE[w_s];
    assign w_step_bad = (popcount3(w_s ^ r_abc_q) >= 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abc_q           <= 3'b000;
            r_f               <= 1'b0;
            r_f_rise          <= 1'b0;
            r_f_fall          <= 1'b0;
            r_step_err        <= 1'b0;
            r_step_err_sticky <= 1'b0;
        end else begin
            r_abc_q           <= w_s;
            r_f               <= w_f_next;
            r_f_rise          <= w_f_next & ~r_f;
            r_f_fall          <= ~w_f_next & r_f;
            r_step_err        <= w_step_bad;
            r_step_err_sticky <= r_step_err_sticky | w_step_bad;
        end
    end

    assign f               = r_f;
    assign abc_q           = r_abc_q;
    assign f_rise          = r_f_rise;
    assign f_fall          = r_f_fall;
    assign step_err        = r_step_err;
    assign step_err_sticky = r_step_err_sticky;

endmodule : p2_rtl
`default_nettype wire

// File: tb/tb_p2_rtl.sv
`default_nettype none
// ============================================================================
// Module      : tb_p2_rtl
// Description : Directed self-checking bench for p2_rtl (default and XOR table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p2_rtl;

    logic       clk;
    logic       rst_n;
    logic       a, b, c;

    logic       f1, rise1, fall1, err1, sticky1;
    logic [2:0] abc1;
    logic       f2, rise2, fall2, err2, sticky2;
    logic [2:0] abc2;

    int n_checks = 0;
    int n_errors = 0;

    p2_rtl u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .c               (c),
        .f               (f1),
        .abc_q           (abc1),
        .f_rise          (rise1),
        .f_fall          (fall1),
        .step_err        (err1),
        .step_err_sticky (sticky1)
    );

    p2_rtl #(
        .TRUTH_TABLE (8'h96)
    ) u_dut_xor (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .c               (c),
        .f               (f2),
        .abc_q           (abc2),
        .f_rise          (rise2),
        .f_fall          (fall2),
        .step_err        (err2),
        .step_err_sticky (sticky2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    // Gray-sweep vectors and hand-derived results (100->001 flips two bits)
    logic [2:0] sw_vec  [8] = '{3'b000, 3'b010, 3'b110, 3'b100, 3'b001, 3'b011, 3'b111, 3'b101};
    logic       sw_f1   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       sw_rise [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       sw_fall [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       sw_err  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       sw_f2   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        set_in(3'b111);
        repeat (3) tick();

        chk("rst_f",      {7'd0, f1},      8'd0);
        chk("rst_abc",    {5'd0, abc1},    8'd0);
        chk("rst_flags",  {4'd0, rise1, fall1, err1, sticky1}, 8'd0);

        // Release with all inputs high: 000 -> 111 seen on the third edge
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel_f_e2",   {7'd0, f1},      8'd0);
        tick();
        chk("rel_f_e3",   {7'd0, f1},      8'd1);
        chk("rel_rise",   {7'd0, rise1},   8'd1);
        chk("rel_err",    {7'd0, err1},    8'd1);
        chk("rel_sticky", {7'd0, sticky1}, 8'd1);
        tick();
        chk("rel_rise_1c", {7'd0, rise1},  8'd0);
        chk("rel_err_1c",  {7'd0, err1},   8'd0);

        // Clean restart from 000
        rst_n = 1'b0;
        set_in(3'b000);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("r2_sticky",  {7'd0, sticky1}, 8'd0);

        // Latency: 000 -> 001
        set_in(3'b001);
        tick();
        chk("lat_e1_f",   {7'd0, f1},      8'd0);
        chk("lat_e1_abc", {5'd0, abc1},    8'd0);
        tick();
        chk("lat_e2_f",   {7'd0, f1},      8'd0);
        chk("lat_e2_abc", {5'd0, abc1},    8'd0);
        tick();
        chk("lat_e3_f",   {7'd0, f1},      8'd1);
        chk("lat_e3_abc", {5'd0, abc1},    8'd1);
        chk("lat_rise",   {7'd0, rise1},   8'd1);
        repeat (6) tick();

        set_in(3'b000);
        repeat (3) tick();
        chk("back_fall",  {7'd0, fall1},   8'd1);
        chk("back_f",     {7'd0, f1},      8'd0);
        repeat (7) tick();

        // Gray-ish sweep on both tables
        for (int i = 0; i < 8; i++) begin
            set_in(sw_vec[i]);
            repeat (3) tick();
            chk($sformatf("sw%0d_f",    i), {7'd0, f1},    {7'd0, sw_f1[i]});
            chk($sformatf("sw%0d_abc",  i), {5'd0, abc1},  {5'd0, sw_vec[i]});
            chk($sformatf("sw%0d_rise", i), {7'd0, rise1}, {7'd0, sw_rise[i]});
            chk($sformatf("sw%0d_fall", i), {7'd0, fall1}, {7'd0, sw_fall[i]});
            chk($sformatf("sw%0d_err",  i), {7'd0, err1},  {7'd0, sw_err[i]});
            chk($sformatf("sw%0d_fx",   i), {7'd0, f2},    {7'd0, sw_f2[i]});
            chk($sformatf("sw%0d_abcx", i), {5'd0, abc2},  {5'd0, sw_vec[i]});
            tick();
            chk($sformatf("sw%0d_pulse_end", i), {5'd0, rise1, fall1, err1}, 8'd0);
            repeat (6) tick();
        end
        chk("sw_sticky",  {7'd0, sticky1}, 8'd1);
        chk("sw_stickyx", {7'd0, sticky2}, 8'd1);

        // Non-Gray step after a clean reset
        rst_n = 1'b0;
        set_in(3'b000);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        set_in(3'b110);
        repeat (3) tick();
        chk("ng_err",     {7'd0, err1},    8'd1);
        chk("ng_sticky",  {7'd0, sticky1}, 8'd1);
        chk("ng_f",       {7'd0, f1},      8'd1);
        tick();
        chk("ng_err_1c",  {7'd0, err1},    8'd0);
        chk("ng_stick_h", {7'd0, sticky1}, 8'd1);
        repeat (6) tick();
        set_in(3'b111);
        repeat (3) tick();
        chk("g1_err",     {7'd0, err1},    8'd0);
        chk("g1_abc",     {5'd0, abc1},    8'd7);
        chk("g1_f",       {7'd0, f1},      8'd1);
        repeat (6) tick();

        // Mid-operation reset: clears before any clock edge
        rst_n = 1'b0;
        #1;
        chk("mid_f",      {7'd0, f1},      8'd0);
        chk("mid_sticky", {7'd0, sticky1}, 8'd0);
        chk("mid_abc",    {5'd0, abc1},    8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_f_e2",   {7'd0, f1},      8'd0);
        tick();
        chk("mid_f_e3",   {7'd0, f1},      8'd1);
        chk("mid_rise",   {7'd0, rise1},   8'd1);
        chk("mid_err",    {7'd0, err1},    8'd1);
        chk("mid_fx",     {7'd0, f2},      8'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_p2_rtl
`default_nettype wire
